dp_ram_arbiter: RTL and testbench
=================================

Name: dp_ram_arbiter

Overview:
Shares one 2^ADDR_W x DATA_W true dual-port synchronous RAM between two masters (m0, m1).
- After reset, sweeps the whole RAM to zero, then grants single-beat read/write requests.
- Resolves same-address conflicts with a round-robin pointer.
- Returns read data with a fixed one-cycle valid strobe.
- Sits between the datapath masters and the dual-port RAM instance; owns every RAM control pin.

Parameters:
ADDR_W, 3, RAM address width; depth = 2^ADDR_W
DATA_W, 3, RAM data width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
m0_req  input  1  master 0 request, held until m0_gnt
m0_we  input  1  master 0 write (1) / read (0)
m0_addr  input  ADDR_W  master 0 address
m0_wdata  input  DATA_W  master 0 write data
m0_gnt  output  1  master 0 request accepted this cycle (combinational)
m0_rvalid  output  1  master 0 read data valid
m0_rdata  output  DATA_W  master 0 read data
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as m0, for master 1
ram_en_a  output  1  RAM port A enable
ram_we_a  output  1  RAM port A write enable
ram_addr_a  output  ADDR_W  RAM port A address
ram_din_a  output  DATA_W  RAM port A write data
ram_dout_a  input  DATA_W  RAM port A read data (1-cycle sync read)
ram_en_b, ram_we_b, ram_addr_b, ram_din_b, ram_dout_b  same as port A, for port B
init_done  output  1  high once the post-reset clear has finished

Behaviour:
- Single clock domain, clk. rst_n is asynchronous assert, synchronous release (external synchroniser).
- Reset values:
  - state=INIT, init_cnt=0, rr=0 (m0 favoured), init_done=0.
  - m*_rvalid=0, m*_rdata=0.
  - All ram_* outputs 0.
  - Stats counter 0 (if compiled in).
- FSM states: INIT, RUN.
  - INIT: ram_en_a=ram_we_a=1, ram_addr_a=init_cnt, ram_din_a=0. Port B idle. m0_gnt=m1_gnt=0. init_cnt increments each cycle.
  - INIT -> RUN on the cycle init_cnt = 2^ADDR_W-1 is written, i.e. after 2^ADDR_W cycles.
  - RUN: init_done=1 from the first RUN cycle. RUN is held until reset.
  - Reset mid-INIT or mid-RUN: immediate return to INIT; pending rvalid is dropped and the sweep restarts at address 0.
- Port mapping in RUN: m0 always drives port A, m1 always drives port B. ram_en_x = gnt_x; ram_we_x = gnt_x & m_we; addr and data pass through.
- Conflict = m0_req & m1_req & (m0_addr == m1_addr) & (m0_we | m1_we).
  - Two reads of the same address are not a conflict.
- No conflict: m*_gnt = m*_req (same cycle).
- Conflict: only the master selected by rr is granted; the other sees gnt=0 and holds its request.
  - rr flips to the loser at the clock edge, so the loser wins next cycle. Worst-case wait is 1 cycle.
  - rr updates only on conflict cycles.
- Read latency: a read granted in cycle N gives m*_rvalid=1 for exactly cycle N+1, with m*_rdata = ram_dout_x.
  - m*_rdata holds its last value when rvalid=0.
- Write-then-read of the same address on consecutive cycles returns the new data, because the RAM write completes at edge N.
- No request buffering: gnt=0 means the transaction did not happen.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds output conflict_cnt [7:0], a saturating count of conflict cycles in RUN. It sticks at 255 and clears only on reset.
  - Adds output stall_m1, high in any cycle m1_req=1 & m1_gnt=0.
- Undefined: neither port nor the counter exists; all other behaviour is identical.

Decomposition:
- Package dp_ram_arb_pkg holds:
  - the state enum {ST_INIT, ST_RUN};
  - default ADDR_W/DATA_W constants;
  - localparam STAT_W=8.
- One sub-module, dp_ram_arb_rr: conflict detect + rr register, producing gnt0/gnt1. The FSM, init sweep and rvalid pipeline stay in the top.

Test Plan:
- Reset release (ADDR_W=3) -> 8 INIT cycles writing 0 to addresses 0..7 on port A; init_done rises on cycle 9; no gnt during INIT, even with m0_req=1.
- m0 write addr 2 data 5, next cycle m1 read addr 2 -> both granted in the same cycle they request; m1_rvalid=1 one cycle later with m1_rdata=5.
- Both write addr 4 (m0 data 3, m1 data 6) from rr=0 -> m0 granted cycle N, m1 granted N+1; final readback of addr 4 = 6; conflict_cnt=1 with ARB_STATS_EN.
- Both read addr 7 in the same cycle -> both granted, no rr change; both rvalid next cycle with data 0.
- Continuous conflicting requests for 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1; no master waits >1 cycle.
- Assert rst_n low mid-RUN while a read is outstanding -> rvalid stays 0, init_done=0, sweep restarts at addr 0; earlier data at addr 2 reads back as 0 afterwards.

Source files
------------

// File: rtl/dp_ram_arb_pkg.sv
// Shared types and constants for the dual-port RAM arbiter.
package dp_ram_arb_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 3;
  localparam int STAT_W     = 8;

endpackage

// File: rtl/dp_ram_arbiter_if.sv
// Master-side request/response bundle for both masters of the RAM arbiter.
interface dp_ram_arbiter_if
  import dp_ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata
  );

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata
  );

endinterface

// File: rtl/dp_ram_arb_rr.sv
// Same-address conflict detection and round-robin grant between the two masters.
// With ARB_STATS_EN defined, also exports the qualified conflict strobe.
module dp_ram_arb_rr #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_run,
  input  logic              i_req0,
  input  logic              i_we0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic              i_req1,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr1,
  output logic              o_gnt0,
  output logic              o_gnt1
`ifdef ARB_STATS_EN
  ,
  output logic              o_conflict
`endif
);

  logic r_rr;
  logic w_conflict;

  // Two reads of one address are harmless; any write makes it a conflict.
  assign w_conflict = i_req0 & i_req1 & (i_addr0 == i_addr1) & (i_we0 | i_we1);

  assign o_gnt0 = i_run & i_req0 & (~w_conflict | ~r_rr);
  assign o_gnt1 = i_run & i_req1 & (~w_conflict | r_rr);

  // Pointer hands priority to the loser, so nobody waits more than one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= 1'b0;
    end else if (i_run && w_conflict) begin
      r_rr <= ~r_rr;
    end
  end

`ifdef ARB_STATS_EN
  assign o_conflict = i_run & w_conflict;
`endif

endmodule

// File: rtl/dp_ram_arbiter.sv
// Arbiter sharing a true dual-port RAM between two masters; clears the RAM after reset.
// Optional ARB_STATS_EN adds a saturating conflict counter and an m1 stall flag.
module dp_ram_arbiter
  import dp_ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  dp_ram_arbiter_if.slave   bus,
  output logic              ram_en_a,
  output logic              ram_we_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_din_a,
  input  logic [DATA_W-1:0] ram_dout_a,
  output logic              ram_en_b,
  output logic              ram_we_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_din_b,
  input  logic [DATA_W-1:0] ram_dout_b,
  output logic              init_done
`ifdef ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] conflict_cnt,
  output logic              stall_m1
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_init_cnt;
  logic              w_run;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
`ifdef ARB_STATS_EN
  logic              w_conflict;
  logic [STAT_W-1:0] r_conflict_cnt;
`endif

  assign w_run = (r_state == ST_RUN);

  dp_ram_arb_rr #(
    .ADDR_W (ADDR_W)
  ) u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_run      (w_run),
    .i_req0     (bus.m0_req),
    .i_we0      (bus.m0_we),
    .i_addr0    (bus.m0_addr),
    .i_req1     (bus.m1_req),
    .i_we1      (bus.m1_we),
    .i_addr1    (bus.m1_addr),
    .o_gnt0     (w_gnt0),
    .o_gnt1     (w_gnt1)
`ifdef ARB_STATS_EN
    ,
    .o_conflict (w_conflict)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_INIT) begin
        r_init_cnt <= r_init_cnt + 1'b1;
      end
    end
  end

  // Port A sweeps zeros during INIT; in RUN each master owns one RAM port.
  always_comb begin
    w_next_state = r_state;
    ram_en_a     = 1'b0;
    ram_we_a     = 1'b0;
    ram_addr_a   = '0;
    ram_din_a    = '0;
    ram_en_b     = 1'b0;
    ram_we_b     = 1'b0;
    ram_addr_b   = '0;
    ram_din_b    = '0;
    case (r_state)
      ST_INIT: begin
        ram_en_a   = 1'b1;
        ram_we_a   = 1'b1;
        ram_addr_a = r_init_cnt;
        if (r_init_cnt == LAST_ADDR) begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        ram_en_a   = w_gnt0;
        ram_we_a   = w_gnt0 & bus.m0_we;
        ram_addr_a = bus.m0_addr;
        ram_din_a  = bus.m0_wdata;
        ram_en_b   = w_gnt1;
        ram_we_b   = w_gnt1 & bus.m1_we;
        ram_addr_b = bus.m1_addr;
        ram_din_b  = bus.m1_wdata;
      end
      default: w_next_state = ST_INIT;
    endcase
    if (!rst_n) begin
      ram_en_a = 1'b0;
      ram_we_a = 1'b0;
      ram_addr_a = '0;
    end
  end

  // Read data arrives straight from the RAM one cycle after the grant; held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= w_gnt0 & ~bus.m0_we;
      r_rvalid1 <= w_gnt1 & ~bus.m1_we;
      if (r_rvalid0) begin
        r_rdata0 <= ram_dout_a;
      end
      if (r_rvalid1) begin
        r_rdata1 <= ram_dout_b;
      end
    end
  end

  assign bus.m0_gnt    = w_gnt0;
  assign bus.m1_gnt    = w_gnt1;
  assign bus.m0_rvalid = r_rvalid0;
  assign bus.m1_rvalid = r_rvalid1;
  assign bus.m0_rdata  = r_rvalid0 ? ram_dout_a : r_rdata0;
  assign bus.m1_rdata  = r_rvalid1 ? ram_dout_b : r_rdata1;
  assign init_done     = w_run;

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict && (r_conflict_cnt != {STAT_W{1'b1}})) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
  assign stall_m1     = bus.m1_req & ~w_gnt1;
`endif

endmodule

// File: tb/tb_dp_ram_arbiter.sv
// Scoreboard bench for dp_ram_arbiter with a behavioural dual-port RAM attached.
// Handles both builds (ARB_STATS_EN defined or not).
module tb_dp_ram_arbiter;

  localparam int AW = 3;
  localparam int DW = 3;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic          ram_en_a, ram_we_a, ram_en_b, ram_we_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_din_a, ram_din_b;
  logic [DW-1:0] ram_dout_a = '0;
  logic [DW-1:0] ram_dout_b = '0;
  logic          init_done;
`ifdef ARB_STATS_EN
  logic [7:0]    conflict_cnt;
  logic          stall_m1;
`endif

  logic [DW-1:0] mem [8] = '{default: 3'd7};
  logic [DW-1:0] exp_mem [8];
  logic          exp_rr;
  int            exp_conf;
  exp_t          q0[$];
  exp_t          q1[$];
  int            cyc    = 0;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  dp_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dp_ram_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .ram_en_a     (ram_en_a),
    .ram_we_a     (ram_we_a),
    .ram_addr_a   (ram_addr_a),
    .ram_din_a    (ram_din_a),
    .ram_dout_a   (ram_dout_a),
    .ram_en_b     (ram_en_b),
    .ram_we_b     (ram_we_b),
    .ram_addr_b   (ram_addr_b),
    .ram_din_b    (ram_din_b),
    .ram_dout_b   (ram_dout_b),
    .init_done    (init_done)
`ifdef ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt),
    .stall_m1     (stall_m1)
`endif
  );

  // Read-first synchronous dual-port RAM.
  always @(posedge clk) begin
    if (ram_en_a) begin
      if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
      ram_dout_a <= mem[ram_addr_a];
    end
    if (ram_en_b) begin
      if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
      ram_dout_b <= mem[ram_addr_b];
    end
  end

  // Scoreboard: each granted read must return exactly one cycle later.
  always @(negedge clk) begin
    if (bus.m0_rvalid === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("[TB] FAIL m0_rvalid_unexpected: got rvalid=1, required 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q0.pop_front();
        if (e.cyc != cyc - 1 || bus.m0_rdata !== e.data) begin
          errors++;
          $display("[TB] FAIL m0_rdata: got %0d in cycle %0d, required %0d in cycle %0d",
                   bus.m0_rdata, cyc, e.data, e.cyc + 1);
        end
      end
    end else if (q0.size() != 0 && q0[0].cyc < cyc) begin
      exp_t e;
      e = q0.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL m0_rvalid_missing: got rvalid=0, required 1 with data %0d (cycle %0d)", e.data, cyc);
    end
    if (bus.m1_rvalid === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("[TB] FAIL m1_rvalid_unexpected: got rvalid=1, required 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        if (e.cyc != cyc - 1 || bus.m1_rdata !== e.data) begin
          errors++;
          $display("[TB] FAIL m1_rdata: got %0d in cycle %0d, required %0d in cycle %0d",
                   bus.m1_rdata, cyc, e.data, e.cyc + 1);
        end
      end
    end else if (q1.size() != 0 && q1[0].cyc < cyc) begin
      exp_t e;
      e = q1.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL m1_rvalid_missing: got rvalid=0, required 1 with data %0d (cycle %0d)", e.data, cyc);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.m0_req = r0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
    bus.m1_req = r1; bus.m1_we = w1; bus.m1_addr = a1; bus.m1_wdata = d1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) exp_mem[i] = '0;
    exp_rr   = 1'b0;
    exp_conf = 0;
  endtask

  task automatic test_reset();
    idle();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ram_en_a !== 1'b0 || ram_we_a !== 1'b0 || ram_en_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ram_ctrl: en_a=%b we_a=%b en_b=%b, required 0 0 0", ram_en_a, ram_we_a, ram_en_b);
    end
    checks++;
    if (init_done !== 1'b0 || bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: init_done=%b rvalid0=%b rvalid1=%b, required 0 0 0",
               init_done, bus.m0_rvalid, bus.m1_rvalid);
    end
    checks++;
    if (bus.m0_rdata !== 3'd0 || bus.m1_rdata !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_rdata: rdata0=%0d rdata1=%0d, required 0 0", bus.m0_rdata, bus.m1_rdata);
    end
`ifdef ARB_STATS_EN
    checks++;
    if (conflict_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_conflict_cnt: got %0d, required 0", conflict_cnt);
    end
`endif
    drive(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (ram_en_a !== 1'b1 || ram_we_a !== 1'b1 || ram_addr_a !== 3'(k) || ram_din_a !== 3'd0 || ram_en_b !== 1'b0) begin
        errors++;
        $display("[TB] FAIL init_sweep_%0d: en_a=%b we_a=%b addr_a=%0d din_a=%0d en_b=%b, required 1 1 %0d 0 0",
                 k, ram_en_a, ram_we_a, ram_addr_a, ram_din_a, ram_en_b, k);
      end
      checks++;
      if (bus.m0_gnt !== 1'b0 || init_done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL init_no_grant_%0d: m0_gnt=%b init_done=%b, required 0 0", k, bus.m0_gnt, init_done);
      end
    end
    idle();
    @(negedge clk);
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL init_done_rise: got %b, required 1", init_done);
    end
    model_clear();
  endtask

  task automatic test_write_read();
    next_cycle();
    drive(1'b1, 1'b1, 3'd2, 3'd5, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (bus.m0_gnt !== 1'b1 || bus.m1_gnt !== 1'b0 || ram_we_a !== 1'b1 || ram_addr_a !== 3'd2 || ram_din_a !== 3'd5) begin
      errors++;
      $display("[TB] FAIL wr_m0: gnt0=%b gnt1=%b we_a=%b addr_a=%0d din_a=%0d, required 1 0 1 2 5",
               bus.m0_gnt, bus.m1_gnt, ram_we_a, ram_addr_a, ram_din_a);
    end
    exp_mem[2] = 3'd5;
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 3'd2, 3'd0);
    @(negedge clk);
    checks++;
    if (bus.m1_gnt !== 1'b1 || bus.m0_gnt !== 1'b0 || ram_en_b !== 1'b1 || ram_we_b !== 1'b0 || ram_addr_b !== 3'd2) begin
      errors++;
      $display("[TB] FAIL rd_m1: gnt1=%b gnt0=%b en_b=%b we_b=%b addr_b=%0d, required 1 0 1 0 2",
               bus.m1_gnt, bus.m0_gnt, ram_en_b, ram_we_b, ram_addr_b);
    end
    q1.push_back('{cyc, exp_mem[2]});
    next_cycle();
    idle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.m1_rvalid !== 1'b0 || bus.m1_rdata !== 3'd5) begin
      errors++;
      $display("[TB] FAIL rdata_hold: rvalid1=%b rdata1=%0d, required 0 5", bus.m1_rvalid, bus.m1_rdata);
    end
  endtask

  task automatic test_write_conflict();
    next_cycle();
    drive(1'b1, 1'b1, 3'd4, 3'd3, 1'b1, 1'b1, 3'd4, 3'd6);
    @(negedge clk);
    checks++;
    if (bus.m0_gnt !== 1'b1 || bus.m1_gnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL conflict_first: gnt0=%b gnt1=%b, required 1 0", bus.m0_gnt, bus.m1_gnt);
    end
`ifdef ARB_STATS_EN
    checks++;
    if (stall_m1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_m1: got %b, required 1", stall_m1);
    end
`endif
    exp_mem[4] = 3'd3;
    exp_rr     = 1'b1;
    exp_conf++;
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 3'd4, 3'd6);
    @(negedge clk);
    checks++;
    if (bus.m1_gnt !== 1'b1 || bus.m0_gnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL conflict_second: gnt0=%b gnt1=%b, required 0 1", bus.m0_gnt, bus.m1_gnt);
    end
    exp_mem[4] = 3'd6;
    next_cycle();
    drive(1'b1, 1'b0, 3'd4, 3'd0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (bus.m0_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL readback4_gnt: got %b, required 1", bus.m0_gnt);
    end
    q0.push_back('{cyc, exp_mem[4]});
`ifdef ARB_STATS_EN
    checks++;
    if (conflict_cnt !== 8'(exp_conf)) begin
      errors++;
      $display("[TB] FAIL conflict_cnt_one: got %0d, required %0d", conflict_cnt, exp_conf);
    end
`endif
  endtask

  task automatic test_read_read();
    next_cycle();
    drive(1'b1, 1'b0, 3'd7, 3'd0, 1'b1, 1'b0, 3'd7, 3'd0);
    @(negedge clk);
    checks++;
    if (bus.m0_gnt !== 1'b1 || bus.m1_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL read_read_gnt: gnt0=%b gnt1=%b, required 1 1", bus.m0_gnt, bus.m1_gnt);
    end
    q0.push_back('{cyc, exp_mem[7]});
    q1.push_back('{cyc, exp_mem[7]});
    // The pointer still favours m1; a fresh write conflict must go its way.
    next_cycle();
    drive(1'b1, 1'b1, 3'd5, 3'd1, 1'b1, 1'b1, 3'd5, 3'd2);
    @(negedge clk);
    checks++;
    if (bus.m0_gnt !== !exp_rr || bus.m1_gnt !== exp_rr) begin
      errors++;
      $display("[TB] FAIL rr_unchanged: gnt0=%b gnt1=%b, required %b %b", bus.m0_gnt, bus.m1_gnt, !exp_rr, exp_rr);
    end
    exp_mem[5] = 3'd2;
    exp_rr     = 1'b0;
    exp_conf++;
    next_cycle();
    drive(1'b1, 1'b1, 3'd5, 3'd1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (bus.m0_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL loser_next: gnt0=%b, required 1", bus.m0_gnt);
    end
    exp_mem[5] = 3'd1;
  endtask

  task automatic test_back_to_back();
    int   wait0 = 0;
    int   wait1 = 0;
    logic win0;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      drive(1'b1, 1'b1, 3'd1, 3'(i), 1'b1, 1'b1, 3'd1, 3'(7 - i));
      @(negedge clk);
      win0 = !exp_rr;
      checks++;
      if (bus.m0_gnt !== win0 || bus.m1_gnt !== !win0 || win0 !== ((i % 2) == 0)) begin
        errors++;
        $display("[TB] FAIL alternate_%0d: gnt0=%b gnt1=%b, required %b %b", i, bus.m0_gnt, bus.m1_gnt, win0, !win0);
      end
      wait0 = (bus.m0_gnt === 1'b1) ? 0 : wait0 + 1;
      wait1 = (bus.m1_gnt === 1'b1) ? 0 : wait1 + 1;
      checks++;
      if (wait0 > 1 || wait1 > 1) begin
        errors++;
        $display("[TB] FAIL max_wait_%0d: wait0=%0d wait1=%0d, required <=1", i, wait0, wait1);
      end
`ifdef ARB_STATS_EN
      checks++;
      if (stall_m1 !== win0) begin
        errors++;
        $display("[TB] FAIL stall_m1_%0d: got %b, required %b", i, stall_m1, win0);
      end
`endif
      exp_mem[1] = win0 ? 3'(i) : 3'(7 - i);
      exp_rr     = win0;
      exp_conf++;
    end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 3'd1, 3'd0);
    @(negedge clk);
    checks++;
    if (bus.m1_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL readback1_gnt: got %b, required 1", bus.m1_gnt);
    end
    q1.push_back('{cyc, exp_mem[1]});
`ifdef ARB_STATS_EN
    checks++;
    if (conflict_cnt !== 8'(exp_conf)) begin
      errors++;
      $display("[TB] FAIL conflict_cnt_total: got %0d, required %0d", conflict_cnt, exp_conf);
    end
`endif
    next_cycle();
    idle();
  endtask

  task automatic test_reset_mid_run();
    next_cycle();
    drive(1'b1, 1'b0, 3'd2, 3'd0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (bus.m0_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_gnt: got %b, required 1", bus.m0_gnt);
    end
    rst_n = 1'b0;
    idle();
    model_clear();
    #1;
    checks++;
    if (init_done !== 1'b0 || bus.m0_rvalid !== 1'b0 || bus.m0_rdata !== 3'd0 || ram_en_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset: init_done=%b rvalid0=%b rdata0=%0d en_a=%b, required 0 0 0 0",
               init_done, bus.m0_rvalid, bus.m0_rdata, ram_en_a);
    end
    @(negedge clk);
    checks++;
    if (bus.m0_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dropped_rvalid: got %b, required 0", bus.m0_rvalid);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ram_en_a !== 1'b1 || ram_we_a !== 1'b1 || ram_addr_a !== 3'd0) begin
      errors++;
      $display("[TB] FAIL sweep_restart: en_a=%b we_a=%b addr_a=%0d, required 1 1 0", ram_en_a, ram_we_a, ram_addr_a);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reinit_done: got %b, required 1", init_done);
    end
`ifdef ARB_STATS_EN
    checks++;
    if (conflict_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL conflict_cnt_cleared: got %0d, required 0", conflict_cnt);
    end
`endif
    next_cycle();
    drive(1'b1, 1'b0, 3'd2, 3'd0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if (bus.m0_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset_gnt: got %b, required 1", bus.m0_gnt);
    end
    q0.push_back('{cyc, exp_mem[2]});
    next_cycle();
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_write_conflict();
    test_read_read();
    test_back_to_back();
    test_reset_mid_run();
    repeat (3) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: q0=%0d q1=%0d entries left, required 0 0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
